// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and helpers for the instruction fetch queue.
// Entry bus layout is {exc, pc, inst}. The exc field is the most significant, inst the least.
package inst_fetch_queue_pkg;

   // Default geometry. The widths match RegBus / InstAddrBus in the core.
   localparam int unsigned IFQ_DEPTH    = 4;
   localparam int unsigned IFQ_PC_W     = 32;
   localparam int unsigned IFQ_INST_W   = 32;
   localparam int unsigned IFQ_EXC_W    = 32;
   localparam int unsigned IFQ_ENTRY_WD = IFQ_EXC_W + IFQ_PC_W + IFQ_INST_W;

   // Per-cycle queue operation, decoded from the push/pop handshakes.
   typedef enum logic [1:0] {
      OpNone = 2'b00,
      OpPush = 2'b01,
      OpPop  = 2'b10,
      OpBoth = 2'b11
   } ifq_op_e;

   function automatic ifq_op_e ifq_op(input logic push, input logic pop);
      return ifq_op_e'({pop, push});
   endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Handshake bundle between the icache stage, the fetch queue and the decoder.
//   in_valid/in_pc/in_inst/in_exc : entry offered by the icache
//   in_ready                      : queue can accept an entry
//   out_valid/out_pc/out_inst/out_exc : head entry (all zero when empty)
//   out_ready                     : decoder consumes the head
// The slave modport is the queue's view. The master modport is the fetch/decode side.
interface inst_fetch_queue_if
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned PC_W   = IFQ_PC_W,
   parameter int unsigned INST_W = IFQ_INST_W,
   parameter int unsigned EXC_W  = IFQ_EXC_W
);
   logic              in_valid;
   logic              in_ready;
   logic [PC_W-1:0]   in_pc;
   logic [INST_W-1:0] in_inst;
   logic [EXC_W-1:0]  in_exc;

   logic              out_valid;
   logic              out_ready;
   logic [PC_W-1:0]   out_pc;
   logic [INST_W-1:0] out_inst;
   logic [EXC_W-1:0]  out_exc;

   modport master (
      output in_valid, in_pc, in_inst, in_exc, out_ready,
      input  in_ready, out_valid, out_pc, out_inst, out_exc
   );

   modport slave (
      input  in_valid, in_pc, in_inst, in_exc, out_ready,
      output in_ready, out_valid, out_pc, out_inst, out_exc
   );
endinterface

// File: rtl/inst_fetch_queue_mem.sv
// ifq_mem: DEPTH x WIDTH register array for the fetch queue.
// It has one synchronous write port and one asynchronous read port. There is no reset,
// because the contents only matter once the pointers mark them valid.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : write data
//   raddr_i : read index
//   rdata_o : read data (combinational)
module ifq_mem #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 96
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: a DEPTH-entry circular FIFO between the icache and the decoder.
// Fetch can run ahead while decode is stalled. When the queue is empty it presents an
// all-zero bubble.
//   clk, rst         : clock and synchronous active-high reset
//   flush_i          : exception/eret flush, which discards all entries
//   br_kill_i        : taken-branch redirect, which discards all entries
//   ifq              : fetch/decode handshake bundle (slave view)
//   count_o          : current occupancy
//   fetch_stallreq_o : occupancy is at or above AF_LEVEL
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH    = IFQ_DEPTH,
   parameter int unsigned PC_W     = IFQ_PC_W,
   parameter int unsigned INST_W   = IFQ_INST_W,
   parameter int unsigned EXC_W    = IFQ_EXC_W,
   parameter int unsigned AF_LEVEL = DEPTH - 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_i,
   input  logic                   br_kill_i,
   inst_fetch_queue_if.slave      ifq,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   fetch_stallreq_o
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned ENTRY_W = EXC_W + PC_W + INST_W;

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic               push, pop, mem_we;
   logic               empty;
   ifq_op_e            op;
   logic [ENTRY_W-1:0] head;

   assign empty = (count_q == '0);

   // in_ready depends only on count, so there is no combinational path from out_ready.
   assign ifq.in_ready  = (count_q != CNT_W'(DEPTH));
   assign ifq.out_valid = !empty;

   assign push = ifq.in_valid & ifq.in_ready;
   assign pop  = ifq.out_valid & ifq.out_ready;
   assign op   = ifq_op(push, pop);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      mem_we   = 1'b0;
      if (flush_i || br_kill_i) begin
         // A redirect wins over any handshake in the same cycle, so the incoming entry is dropped.
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         mem_we = push;
         unique case (op)
            OpPush: begin
               wr_ptr_d = wr_ptr_q + PTR_W'(1);
               count_d  = count_q + CNT_W'(1);
            end
            OpPop: begin
               rd_ptr_d = rd_ptr_q + PTR_W'(1);
               count_d  = count_q - CNT_W'(1);
            end
            OpBoth: begin
               wr_ptr_d = wr_ptr_q + PTR_W'(1);
               rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   ifq_mem #(
      .DEPTH(DEPTH),
      .WIDTH(ENTRY_W)
   ) u_mem (
      .clk    (clk),
      .we_i   (mem_we),
      .waddr_i(wr_ptr_q),
      .wdata_i({ifq.in_exc, ifq.in_pc, ifq.in_inst}),
      .raddr_i(rd_ptr_q),
      .rdata_o(head)
   );

   // Gate stale storage to the zero bubble when empty.
   assign ifq.out_exc  = empty ? '0 : head[ENTRY_W-1 -: EXC_W];
   assign ifq.out_pc   = empty ? '0 : head[PC_W+INST_W-1 -: PC_W];
   assign ifq.out_inst = empty ? '0 : head[INST_W-1:0];

   assign count_o          = count_q;
   assign fetch_stallreq_o = (count_q >= CNT_W'(AF_LEVEL));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH=4, AF_LEVEL=3).
module tb_inst_fetch_queue;

   logic       clk;
   logic       rst;
   logic       flush;
   logic       br_kill;
   logic [2:0] count;
   logic       stallreq;

   int n_checks;
   int n_fail;

   inst_fetch_queue_if #(.PC_W(32), .INST_W(32), .EXC_W(32)) bus ();

   inst_fetch_queue #(
      .DEPTH   (4),
      .PC_W    (32),
      .INST_W  (32),
      .EXC_W   (32),
      .AF_LEVEL(3)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .flush_i         (flush),
      .br_kill_i       (br_kill),
      .ifq             (bus),
      .count_o         (count),
      .fetch_stallreq_o(stallreq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock edge, then let the outputs settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_in(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                           input logic [31:0] exc);
      bus.in_valid = v;
      bus.in_pc    = pc;
      bus.in_inst  = inst;
      bus.in_exc   = exc;
   endtask

   task automatic check_bubble(input string tag);
      check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
      check({tag, ".out_pc"},    bus.out_pc,         32'd0);
      check({tag, ".out_inst"},  bus.out_inst,       32'd0);
      check({tag, ".out_exc"},   bus.out_exc,        32'd0);
      check({tag, ".count"},     32'(count),         32'd0);
      check({tag, ".in_ready"},  32'(bus.in_ready),  32'd1);
   endtask

   // Push three entries with out_ready low, starting from empty.
   task automatic fill3(input logic [31:0] base);
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_in(1'b1, base + 32'(4 * i), base + 32'(i), 32'd0);
         tick();
      end
      drive_in(1'b0, 32'd0, 32'd0, 32'd0);
      check("fill3.count", 32'(count), 32'd3);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      flush    = 1'b0;
      br_kill  = 1'b0;
      bus.out_ready = 1'b0;
      drive_in(1'b0, 32'd0, 32'd0, 32'd0);

      // Reset and idle.
      tick();
      tick();
      rst = 1'b0;
      tick();
      check_bubble("reset");
      check("reset.stallreq", 32'(stallreq), 32'd0);

      // Fill to full. The exc field carries a distinct tag per entry.
      for (int i = 0; i < 4; i++) begin
         drive_in(1'b1, 32'hBFC0_0000 + 32'(4 * i), 32'h2401_0001 + 32'(i), 32'(i) << 4);
         tick();
         check("fill.count",    32'(count),        32'(i + 1));
         check("fill.stallreq", 32'(stallreq),     32'((i + 1) >= 3));
         check("fill.in_ready", 32'(bus.in_ready), 32'((i + 1) < 4));
         check("fill.head_pc",  bus.out_pc,        32'hBFC0_0000);
      end

      // A fifth offer while full must be ignored.
      drive_in(1'b1, 32'hBFC0_0010, 32'h2401_0005, 32'd0);
      tick();
      check("full.count",     32'(count),   32'd4);
      check("full.head_pc",   bus.out_pc,   32'hBFC0_0000);
      check("full.head_inst", bus.out_inst, 32'h2401_0001);

      // Drain in order.
      drive_in(1'b0, 32'd0, 32'd0, 32'd0);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain.valid", 32'(bus.out_valid), 32'd1);
         check("drain.inst",  bus.out_inst,       32'h2401_0001 + 32'(i));
         check("drain.pc",    bus.out_pc,         32'hBFC0_0000 + 32'(4 * i));
         check("drain.exc",   bus.out_exc,        32'(i) << 4);
         tick();
      end
      check_bubble("drained");

      // Simultaneous push and pop at count 1.
      bus.out_ready = 1'b0;
      drive_in(1'b1, 32'h0000_0100, 32'h0000_000A, 32'd0);
      tick();
      check("pp.count1", 32'(count), 32'd1);
      bus.out_ready = 1'b1;
      drive_in(1'b1, 32'h0000_0104, 32'h0000_000B, 32'h0000_0008);
      tick();
      check("pp.count",     32'(count),   32'd1);
      check("pp.head_pc",   bus.out_pc,   32'h0000_0104);
      check("pp.head_inst", bus.out_inst, 32'h0000_000B);
      check("pp.head_exc",  bus.out_exc,  32'h0000_0008);
      drive_in(1'b0, 32'd0, 32'd0, 32'd0);
      tick();
      check("pp.empty", 32'(count), 32'd0);

      // Pointer wrap: 10 entries streamed with a steady occupancy of 2.
      for (int k = 0; k < 12; k++) begin
         int pushes;
         int pops;
         bus.out_ready = (k >= 2);
         if (k < 10) drive_in(1'b1, 32'h2000 + 32'(4 * k), 32'h1000 + 32'(k), 32'd0);
         else        drive_in(1'b0, 32'd0, 32'd0, 32'd0);
         if (k >= 2) begin
            check("wrap.inst", bus.out_inst, 32'h1000 + 32'(k - 2));
            check("wrap.pc",   bus.out_pc,   32'h2000 + 32'(4 * (k - 2)));
         end
         tick();
         pushes = (k + 1 < 10) ? k + 1 : 10;
         pops   = (k >= 2) ? k - 1 : 0;
         check("wrap.count", 32'(count), 32'(pushes - pops));
      end
      bus.out_ready = 1'b0;

      // br_kill racing a push and a pop.
      fill3(32'h0000_3000);
      bus.out_ready = 1'b1;
      drive_in(1'b1, 32'h0000_3FFC, 32'h0000_3FFF, 32'd0);
      br_kill = 1'b1;
      tick();
      br_kill = 1'b0;
      drive_in(1'b0, 32'd0, 32'd0, 32'd0);
      bus.out_ready = 1'b0;
      check_bubble("brkill");
      tick();
      check("brkill.dropped", 32'(count), 32'd0);
      drive_in(1'b1, 32'h0000_4000, 32'h0000_4444, 32'd0);
      tick();
      drive_in(1'b0, 32'd0, 32'd0, 32'd0);
      check("brkill.recover_inst", bus.out_inst, 32'h0000_4444);
      check("brkill.recover_cnt",  32'(count),   32'd1);
      bus.out_ready = 1'b1;
      tick();

      // Flush racing a push.
      fill3(32'h0000_5000);
      drive_in(1'b1, 32'h0000_5FFC, 32'h0000_5FFF, 32'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive_in(1'b0, 32'd0, 32'd0, 32'd0);
      check_bubble("flush");
      check("flush.stallreq", 32'(stallreq), 32'd0);

      // Reset together with flush, mid-stream.
      fill3(32'h0000_6000);
      drive_in(1'b1, 32'h0000_6FFC, 32'h0000_6FFF, 32'd0);
      rst   = 1'b1;
      flush = 1'b1;
      tick();
      rst   = 1'b0;
      flush = 1'b0;
      drive_in(1'b0, 32'd0, 32'd0, 32'd0);
      check_bubble("rstflush");
      drive_in(1'b1, 32'h0000_7000, 32'h0000_7777, 32'd0);
      tick();
      drive_in(1'b0, 32'd0, 32'd0, 32'd0);
      check("rstflush.recover_pc", bus.out_pc, 32'h0000_7000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
